// File: rtl/seg7_mux_decoder.sv
// Monitors a two-digit multiplexed seven-segment display and recovers the shown byte,
// the decimal points, and lock status from the digit-enable and segment lines.
module seg7_mux_decoder #(
   parameter int STABLE  = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       en_hi,
   input  logic       en_lo,
   input  logic [6:0] seg,
   input  logic       dp,
   output logic [7:0] value,
   output logic       dp_hi,
   output logic       dp_lo,
   output logic       valid,
   output logic       upd,
   output logic       changed,
   output logic       err
);

   typedef enum logic [1:0] {SEEK, NEED_HI, NEED_LO, LOCKED} state_t;

   localparam logic [7:0]  STB    = 8'(STABLE);
   localparam logic [7:0]  STB_M1 = 8'(STABLE - 1);
   localparam logic [15:0] TMO    = 16'(TIMEOUT);
   localparam logic [15:0] TMO_M1 = 16'(TIMEOUT - 1);

   // Returns {hit, nibble}; hit=0 for patterns outside the hex code table.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'b1111110: decode = 5'h10;
         7'b0110000: decode = 5'h11;
         7'b1101101: decode = 5'h12;
         7'b1111001: decode = 5'h13;
         7'b0110011: decode = 5'h14;
         7'b1011011: decode = 5'h15;
         7'b1011111: decode = 5'h16;
         7'b1110000: decode = 5'h17;
         7'b1111111: decode = 5'h18;
         7'b1111011: decode = 5'h19;
         7'b1110111: decode = 5'h1A;
         7'b0011111: decode = 5'h1B;
         7'b1001110: decode = 5'h1C;
         7'b0111101: decode = 5'h1D;
         7'b1001111: decode = 5'h1E;
         7'b1000111: decode = 5'h1F;
         default:    decode = 5'h00;
      endcase
   endfunction

   logic [9:0]  sync1, v, v_prev;
   logic [7:0]  scnt;
   logic [15:0] tcnt;
   logic [3:0]  sh_hi, sh_lo;
   logic        sh_dp_hi, sh_dp_lo;
   state_t      state, state_n;
   logic        publish;

   logic       is_hi, is_lo, stable, accept, good, bad, timeout;
   logic [4:0] dec;
   logic [3:0] nxt_hi, nxt_lo;
   logic       nxt_dp_hi, nxt_dp_lo;
   logic [7:0] new_value;

   assign is_hi   = v[9] & ~v[8];
   assign is_lo   = ~v[9] & v[8];
   assign stable  = (v == v_prev) && (v[9] ^ v[8]);
   assign accept  = stable && (scnt == STB_M1);
   assign dec     = decode(v[7:1]);
   assign good    = accept & dec[4];
   assign bad     = accept & ~dec[4];
   assign timeout = !good && (tcnt == TMO_M1);

   // Shadow contents including the digit being accepted this cycle.
   assign nxt_hi    = (good && is_hi) ? dec[3:0] : sh_hi;
   assign nxt_lo    = (good && is_lo) ? dec[3:0] : sh_lo;
   assign nxt_dp_hi = (good && is_hi) ? v[0] : sh_dp_hi;
   assign nxt_dp_lo = (good && is_lo) ? v[0] : sh_dp_lo;
   assign new_value = {nxt_hi, nxt_lo};

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) state <= SEEK;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      publish = 1'b0;
      case (state)
         SEEK: begin
            if (good) state_n = is_hi ? NEED_LO : NEED_HI;
         end
         NEED_HI: begin
            if (good) begin
               if (is_hi) begin
                  state_n = LOCKED;
                  publish = 1'b1;
               end
            end else if (timeout) state_n = SEEK;
         end
         NEED_LO: begin
            if (good) begin
               if (is_lo) begin
                  state_n = LOCKED;
                  publish = 1'b1;
               end
            end else if (timeout) state_n = SEEK;
         end
         LOCKED: begin
            if (good)         publish = 1'b1;
            else if (timeout) state_n = SEEK;
         end
         default: state_n = SEEK;
      endcase
   end

   // A publish out of NEED_HI/NEED_LO is always the first since SEEK.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         sync1    <= '0;
         v        <= '0;
         v_prev   <= '0;
         scnt     <= '0;
         tcnt     <= '0;
         sh_hi    <= '0;
         sh_lo    <= '0;
         sh_dp_hi <= 1'b0;
         sh_dp_lo <= 1'b0;
         value    <= '0;
         dp_hi    <= 1'b0;
         dp_lo    <= 1'b0;
         valid    <= 1'b0;
         upd      <= 1'b0;
         changed  <= 1'b0;
         err      <= 1'b0;
      end else begin
         sync1  <= {en_hi, en_lo, seg, dp};
         v      <= sync1;
         v_prev <= v;
         if (!stable)          scnt <= '0;
         else if (scnt != STB) scnt <= scnt + 8'd1;
         if (good)             tcnt <= '0;
         else if (tcnt != TMO) tcnt <= tcnt + 16'd1;
         sh_hi    <= nxt_hi;
         sh_lo    <= nxt_lo;
         sh_dp_hi <= nxt_dp_hi;
         sh_dp_lo <= nxt_dp_lo;
         if (publish) begin
            value <= new_value;
            dp_hi <= nxt_dp_hi;
            dp_lo <= nxt_dp_lo;
         end
         upd     <= publish;
         changed <= publish && ((state != LOCKED) || (new_value != value));
         valid   <= (state_n == LOCKED);
         err     <= err | bad;
      end
   end

endmodule

// File: tb/tb_seg7_mux_decoder.sv
// Directed bench for seg7_mux_decoder: lock, glitch rejection, bad codes, timeout and reset.
module tb_seg7_mux_decoder;

   localparam int STABLE  = 4;
   localparam int TIMEOUT = 300;

   localparam logic [6:0] S_5   = 7'b1011011;
   localparam logic [6:0] S_A   = 7'b1110111;
   localparam logic [6:0] S_3   = 7'b1111001;
   localparam logic [6:0] S_C   = 7'b1001110;
   localparam logic [6:0] S_BAD = 7'b0000001;

   logic       CLK = 1'b0;
   logic       rst;
   logic       en_hi, en_lo, dp;
   logic [6:0] seg;
   logic [7:0] value;
   logic       dp_hi, dp_lo, valid, upd, changed, err;

   int checks = 0;
   int fails  = 0;
   int upd_cnt = 0;
   int base;

   seg7_mux_decoder #(.STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .rst(rst), .en_hi(en_hi), .en_lo(en_lo), .seg(seg), .dp(dp),
      .value(value), .dp_hi(dp_hi), .dp_lo(dp_lo), .valid(valid),
      .upd(upd), .changed(changed), .err(err)
   );

   always #5 CLK = ~CLK;

   // Counts upd pulses, sampled shortly after each active edge.
   always @(posedge CLK) begin
      #1;
      if (upd === 1'b1) upd_cnt++;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic put(input logic h, input logic l, input logic [6:0] s, input logic d);
      en_hi = h;
      en_lo = l;
      seg   = s;
      dp    = d;
   endtask

   initial begin
      rst = 1'b1;
      put(1'b0, 1'b0, 7'b0, 1'b0);
      step(3);
      check("rst_value",   value,   8'h00);
      check("rst_dp_hi",   dp_hi,   1'b0);
      check("rst_dp_lo",   dp_lo,   1'b0);
      check("rst_valid",   valid,   1'b0);
      check("rst_upd",     upd,     1'b0);
      check("rst_changed", changed, 1'b0);
      check("rst_err",     err,     1'b0);

      rst = 1'b0;
      base = upd_cnt;
      step(100);
      check("idle_upd_cnt", 8'(upd_cnt - base), 8'd0);
      check("idle_valid",   valid, 1'b0);

      // Lo "5" then hi "A"; publish 2+STABLE edges into the hi digit.
      put(1'b0, 1'b1, S_5, 1'b1);
      step(64);
      check("lo_only_upd_cnt", 8'(upd_cnt - base), 8'd0);
      check("lo_only_valid",   valid, 1'b0);
      put(1'b1, 1'b0, S_A, 1'b0);
      step(6);
      check("first_upd_early", upd, 1'b0);
      step(1);
      check("first_upd",     upd,     1'b1);
      check("first_value",   value,   8'hA5);
      check("first_dp_lo",   dp_lo,   1'b1);
      check("first_dp_hi",   dp_hi,   1'b0);
      check("first_valid",   valid,   1'b1);
      check("first_changed", changed, 1'b1);
      step(1);
      check("first_upd_pulse",     upd,     1'b0);
      check("first_changed_pulse", changed, 1'b0);
      step(56);
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) put(1'b0, 1'b1, S_5, 1'b1);
         else            put(1'b1, 1'b0, S_A, 1'b0);
         step(7);
         check("alt_upd",     upd,     1'b1);
         check("alt_changed", changed, 1'b0);
         check("alt_value",   value,   8'hA5);
         step(57);
      end

      // Reset while locked clears outputs at once.
      rst = 1'b1;
      #1;
      check("midrst_value", value, 8'h00);
      check("midrst_valid", valid, 1'b0);
      check("midrst_dp_lo", dp_lo, 1'b0);
      step(2);
      rst = 1'b0;

      // Digits held 3 cycles are never accepted.
      base = upd_cnt;
      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 0) put(1'b0, 1'b1, S_5, 1'b1);
         else            put(1'b1, 1'b0, S_A, 1'b0);
         step(3);
      end
      check("glitch_upd_cnt", 8'(upd_cnt - base), 8'd0);
      check("glitch_valid",   valid, 1'b0);
      put(1'b0, 1'b1, S_5, 1'b1);
      step(64);
      check("reacq_one_digit_cnt", 8'(upd_cnt - base), 8'd0);
      check("reacq_one_value",     value, 8'h00);
      put(1'b1, 1'b0, S_A, 1'b0);
      step(7);
      check("reacq_upd",   upd,   1'b1);
      check("reacq_value", value, 8'hA5);
      check("reacq_valid", valid, 1'b1);
      step(57);

      // Bad pattern on the lo digit: err sticks, value untouched, shadow lo stays 5.
      base = upd_cnt;
      put(1'b0, 1'b1, S_BAD, 1'b0);
      step(64);
      check("bad_err",     err,   1'b1);
      check("bad_value",   value, 8'hA5);
      check("bad_upd_cnt", 8'(upd_cnt - base), 8'd0);
      put(1'b1, 1'b0, S_3, 1'b1);
      step(7);
      check("after_bad_upd",     upd,     1'b1);
      check("after_bad_value",   value,   8'h35);
      check("after_bad_changed", changed, 1'b1);
      check("after_bad_dp_hi",   dp_hi,   1'b1);
      check("after_bad_dp_lo",   dp_lo,   1'b1);
      step(57);
      put(1'b0, 1'b1, S_C, 1'b0);
      step(7);
      check("lo_c_value", value, 8'h3C);
      check("lo_c_dp_lo", dp_lo, 1'b0);
      check("err_sticky", err,   1'b1);

      // Timeout with idle enables drops valid, holds value.
      put(1'b0, 1'b0, 7'b0, 1'b0);
      step(TIMEOUT - 2);
      check("pre_timeout_valid", valid, 1'b1);
      step(3);
      check("timeout_valid", valid, 1'b0);
      check("timeout_value", value, 8'h3C);

      // Same byte after timeout still reports changed.
      base = upd_cnt;
      put(1'b1, 1'b0, S_3, 1'b1);
      step(64);
      check("resume_hi_only_cnt", 8'(upd_cnt - base), 8'd0);
      check("resume_hi_valid",    valid, 1'b0);
      put(1'b0, 1'b1, S_C, 1'b0);
      step(7);
      check("resume_upd",     upd,     1'b1);
      check("resume_changed", changed, 1'b1);
      check("resume_value",   value,   8'h3C);
      check("resume_valid",   valid,   1'b1);
      step(10);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
